shift_deserializer: RTL and testbench

- Serial-in, parallel-out word assembler: the receive end of the bit-serial link that is fed by the datapath shift logic.
- Accepts one bit per cycle under a valid/ready handshake and packs WIDTH bits into a word, MSB-first or LSB-first.
- Presents the completed word on a valid/ready output port with one-word buffering, so the next word can fill while the previous word waits.
- Sits between a serial source (debug/IO link) and the CPU bus-side register interface.

---
 rtl/shift_deserializer_pkg.sv | 17 +
 rtl/shift_deserializer_out_reg.sv | 47 ++++
 rtl/shift_deserializer.sv | 110 +++++++++++
 tb/tb_shift_deserializer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_deserializer_pkg.sv
// Shared types and constants for the serial-in word assembler.
package shift_pkg;

    // Fill-side states. FULL_STALL is only ever reached combinationally: it is
    // LAST seen through a blocked output port.
    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        LAST,
        FULL_STALL
    } fill_state_t;

    // Shift direction encoding shared with the datapath shifter.
    localparam logic DIR_LEFT  = 1'b0;   // MSB-first: shift left, new bit enters LSB
    localparam logic DIR_RIGHT = 1'b1;   // LSB-first: shift right, new bit enters MSB

endpackage

// File: rtl/shift_deserializer_out_reg.sv
// Single-entry output holding register with a valid/ready drain side.
// A load and a drain in the same cycle keep valid high with the new word.
module shift_out_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // Next-state: a load wins over a drain; data only changes on a load so it
    // stays stable while the consumer is stalling.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = load_data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // State register with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/shift_deserializer.sv
// Serial-in, parallel-out word assembler. Packs WIDTH bits, MSB- or LSB-first,
// into a word and hands it to a one-entry valid/ready output buffer.
module shift_deserializer
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             bit_ready,
    input  logic             lsb_first,
    input  logic             frame_abort,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_data,
    output logic [CNT_W-1:0] bits_pending
);

    localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(WIDTH - 2);

    fill_state_t      state_q, state_d, fill_state;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] sr_q,    sr_d;
    logic             lsb_q,   lsb_d;

    logic             accept;
    logic             complete;
    logic             dir;
    logic [WIDTH-1:0] shifted;

    // The stall view depends on word_ready this cycle, so a drain can free the
    // last bit slot in the same cycle the word completes.
    assign fill_state = (state_q == LAST && word_valid && !word_ready) ? FULL_STALL : state_q;
    assign bit_ready  = !rst && !frame_abort && (fill_state != FULL_STALL);
    assign accept     = bit_valid && bit_ready;
    assign complete   = accept && (cnt_q == LAST_CNT);

    // Direction is taken live on the first bit of a word, then held in lsb_q.
    assign dir     = (cnt_q == '0) ? lsb_first : lsb_q;
    assign shifted = (dir == DIR_RIGHT) ? {bit_in, sr_q[WIDTH-1:1]}
                                        : {sr_q[WIDTH-2:0], bit_in};

    // Fill-side next state: counter, shift register, direction and FSM state.
    // NOTE: every signal gets its default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        lsb_d   = lsb_q;

        if (accept) begin
            lsb_d = dir;
            if (complete) begin
                cnt_d = '0;
                sr_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                sr_d  = shifted;
            end
        end

        unique case (fill_state)
            EMPTY, FILLING: if (accept) state_d = (cnt_q == PRE_LAST_CNT) ? LAST : FILLING;
            LAST:           if (accept) state_d = EMPTY;
            FULL_STALL:     state_d = LAST;
            default:        state_d = EMPTY;
        endcase

        if (frame_abort) begin
            state_d = EMPTY;
            cnt_d   = '0;
            sr_d    = '0;
        end
    end

    // Fill-side registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            sr_q    <= '0;
            lsb_q   <= DIR_LEFT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            lsb_q   <= lsb_d;
        end
    end

    shift_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .load_i      (complete),
        .load_data_i (shifted),
        .ready_i     (word_ready),
        .valid_o     (word_valid),
        .data_o      (word_data)
    );

    assign bits_pending = cnt_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer: a bit-position model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_shift_deserializer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         bit_valid, bit_in, bit_ready, lsb_first, frame_abort;
    logic         word_valid, word_ready;
    logic [W-1:0] word_data;
    logic [4:0]   bits_pending;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model state: bits placed by position, not by shifting.
    logic [W-1:0] m_acc   = '0;
    int           m_k     = 0;
    logic         m_dir   = 1'b0;
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    bit           m_started = 1'b0;

    // Words seen leaving the DUT and the cycle each left.
    logic [W-1:0] got_words[$];
    int           got_cyc[$];

    shift_deserializer #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bit_valid    (bit_valid),
        .bit_in       (bit_in),
        .bit_ready    (bit_ready),
        .lsb_first    (lsb_first),
        .frame_abort  (frame_abort),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .word_data    (word_data),
        .bits_pending (bits_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic model_ready();
        return !rst && !frame_abort && !(m_k == W - 1 && m_valid && !word_ready);
    endfunction

    // Model update at each edge from the inputs held over that edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_acc = '0; m_k = 0; m_dir = 1'b0; m_valid = 1'b0; m_data = '0;
            end else begin
                logic acc, drain, done;
                acc   = bit_valid && model_ready();
                drain = m_valid && word_ready;
                done  = 1'b0;
                if (frame_abort) begin
                    m_k = 0; m_acc = '0;
                end else if (acc) begin
                    if (m_k == 0) m_dir = lsb_first;
                    m_acc[m_dir ? m_k : (W - 1 - m_k)] = bit_in;
                    m_k++;
                    if (m_k == W) begin
                        done = 1'b1; m_data = m_acc; m_k = 0; m_acc = '0;
                    end
                end
                if (done) m_valid = 1'b1;
                else if (drain) m_valid = 1'b0;
            end
            m_started = 1'b1;
        end
    end

    // Compare process: DUT against model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_started) begin
                check("bit_ready",    bit_ready,    model_ready());
                check("word_valid",   word_valid,   m_valid);
                check("word_data",    word_data,    m_data);
                check("bits_pending", bits_pending, m_k);
            end
        end
    end

    // Output handshake log.
    initial begin
        forever begin
            @(posedge clk);
            if (word_valid === 1'b1 && word_ready === 1'b1) begin
                got_words.push_back(word_data);
                got_cyc.push_back(cyc);
            end
            cyc++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one bit until it is accepted; returns just after the accepting edge.
    task automatic send_bit(input logic b, input logic lsb);
        logic acc;
        int   guard = 0;
        bit_valid = 1'b1;
        bit_in    = b;
        lsb_first = lsb;
        forever begin
            @(negedge clk);
            acc = bit_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            guard++;
            if (guard > 200) begin
                check("send_bit_timeout", 1'b0, 1'b1);
                break;
            end
        end
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic lsb);
        for (int i = 0; i < W; i++) send_bit(lsb ? w[i] : w[W-1-i], lsb);
        bit_valid = 1'b0;
    endtask

    initial begin
        int n0;
        bit low_seen;
        logic [W-1:0] w;

        rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; lsb_first = 1'b0;
        frame_abort = 1'b0; word_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bit_ready", bit_ready, 1'b0);
        check("rst_word_valid", word_valid, 1'b0);
        check("rst_word_data", word_data, '0);
        check("rst_bits_pending", bits_pending, 5'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: MSB-first single word, consumer always ready.
        word_ready = 1'b1;
        send_word(32'hDEADBEEF, 1'b0);
        check("t1_valid", word_valid, 1'b1);
        check("t1_data", word_data, 32'hDEADBEEF);
        check("t1_pending", bits_pending, 5'd0);
        @(posedge clk); #1;
        check("t1_valid_one_cycle", word_valid, 1'b0);

        // 2: LSB-first, then a mid-word direction toggle that must be ignored.
        send_word(32'h00000001, 1'b1);
        check("t2a_data", word_data, 32'h00000001);
        w = 32'h80000000;
        for (int i = 0; i < W; i++) send_bit(w[i], (i < 5) ? 1'b1 : 1'b0);
        bit_valid = 1'b0;
        check("t2b_data", word_data, 32'h80000000);
        @(posedge clk); #1;

        // 3: backpressure, stall on the last bit, then drain and complete together.
        word_ready = 1'b0;
        send_word(32'h12345678, 1'b0);
        check("t3_first_valid", word_valid, 1'b1);
        fork
            send_word(32'hCAFEF00D, 1'b0);
            begin
                int g = 0;
                while (bits_pending != 5'd31 && g < 200) begin
                    @(negedge clk);
                    g++;
                end
                check("t3_reach31", bits_pending, 5'd31);
                repeat (3) @(negedge clk);
                check("t3_stall_ready", bit_ready, 1'b0);
                check("t3_hold_data", word_data, 32'h12345678);
                @(posedge clk); #1;
                word_ready = 1'b1;
            end
        join
        check("t3_drained_first", got_words[$], 32'h12345678);
        check("t3_second_valid", word_valid, 1'b1);
        check("t3_second_data", word_data, 32'hCAFEF00D);
        @(posedge clk); #1;
        check("t3_second_drained", got_words[$], 32'hCAFEF00D);

        // 4: abort a partial word; the abort-cycle bit is dropped.
        n0 = got_words.size();
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
        bit_in = 1'b1; frame_abort = 1'b1;
        @(negedge clk);
        check("t4_abort_ready", bit_ready, 1'b0);
        @(posedge clk); #1;
        frame_abort = 1'b0; bit_valid = 1'b0;
        check("t4_pending_cleared", bits_pending, 5'd0);
        send_word(32'hA5A5A5A5, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        check("t4_word_count", got_words.size() - n0, 1);
        check("t4_word", got_words[$], 32'hA5A5A5A5);

        // 5: drain of word A and completion of word B on the same edge.
        word_ready = 1'b0;
        send_word(32'h0F0F0F0F, 1'b0);
        n0 = got_words.size();
        low_seen = 1'b0;
        w = 32'h13579BDF;
        for (int i = 0; i < W - 1; i++) begin
            send_bit(w[W-1-i], 1'b0);
            if (word_valid !== 1'b1) low_seen = 1'b1;
        end
        word_ready = 1'b1;
        send_bit(w[0], 1'b0);
        bit_valid = 1'b0;
        check("t5_no_gap", low_seen, 1'b0);
        check("t5_valid", word_valid, 1'b1);
        check("t5_data", word_data, 32'h13579BDF);
        @(posedge clk); #1;
        check("t5_count", got_words.size() - n0, 2);
        check("t5_first", got_words[n0], 32'h0F0F0F0F);
        check("t5_second", got_words[n0+1], 32'h13579BDF);
        check("t5_consecutive", got_cyc[n0+1] - got_cyc[n0], 1);

        // 6: reset mid-word with a held output word.
        word_ready = 1'b0;
        send_word(32'h11111111, 1'b0);
        for (int i = 0; i < 17; i++) send_bit(1'b1, 1'b0);
        bit_valid = 1'b0;
        check("t6_held_valid", word_valid, 1'b1);
        check("t6_pending17", bits_pending, 5'd17);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_ready", bit_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_valid_cleared", word_valid, 1'b0);
        check("t6_data_cleared", word_data, '0);
        check("t6_pending_cleared", bits_pending, 5'd0);
        word_ready = 1'b1;
        send_word(32'h0000FFFF, 1'b0);
        check("t6_fresh_valid", word_valid, 1'b1);
        check("t6_fresh_data", word_data, 32'h0000FFFF);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
